// File: rtl/stim.sv
// Test-program sequencer: fetches VECTOR / BITMASK / END records over an Avalon-MM read
// master and turns them into STIM_FIFO, CHECK_FIFO and checker-command writes.
module stim #(
  parameter int ADDR_WIDTH          = 20,
  parameter int DATA_WIDTH          = 16,
  parameter int STF_WIDTH           = 24,
  parameter int RTF_WIDTH           = 24,
  parameter int CHF_WIDTH           = 44,
  parameter int SCC_WIDTH           = 5,
  parameter int SCD_WIDTH           = 24,
  parameter int RESULT_VECTOR_WORDS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] res_base,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           vec_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_waitrequest,
  output logic [STF_WIDTH-1:0]  sfifo_data,
  output logic                  sfifo_wrreq,
  input  logic                  sfifo_wrfull,
  input  logic                  sfifo_wrempty,
  output logic [CHF_WIDTH-1:0]  cfifo_data,
  output logic                  cfifo_wrreq,
  input  logic                  cfifo_wrfull,
  output logic [SCC_WIDTH-1:0]  sc_cmd,
  output logic [SCD_WIDTH-1:0]  sc_data,
  input  logic                  sc_ready
);

  typedef enum logic [2:0] {
    IDLE, RD_META, RD_BODY, PUSH, WAIT_DRAIN, SEND_MASK, DONE
  } state_t;

  state_t state, next_state;

  logic [STF_WIDTH-1:0]  stim_vec;
  logic [RTF_WIDTH-1:0]  exp_vec;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [1:0]            idx;
  logic                  is_vec;
  logic                  accept;
  logic                  start_ok;
  logic [7:0]            rec_type;
  logic [1:0]            last_idx;

  assign rec_type   = mem_readdata[15:8];
  assign accept     = (state == RD_META || state == RD_BODY) && !mem_waitrequest;
  assign start_ok   = (state == IDLE || state == DONE) && start;
  assign last_idx   = is_vec ? 2'd3 : 2'd1;
  assign busy       = !(state == IDLE || state == DONE);
  assign done       = (state == DONE);
  assign sfifo_data = stim_vec;
  assign cfifo_data = {exp_vec, res_addr};
  // A bitmask record reuses the stimulus holding register for its payload.
  assign sc_data    = (state == SEND_MASK) ? stim_vec : '0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    mem_read    = 1'b0;
    sfifo_wrreq = 1'b0;
    cfifo_wrreq = 1'b0;
    sc_cmd      = '0;
    case (state)
      IDLE, DONE: if (start) next_state = RD_META;
      RD_META: begin
        mem_read = 1'b1;
        if (accept) begin
          case (rec_type)
            8'h01, 8'h02: next_state = RD_BODY;
            default:      next_state = DONE;
          endcase
        end
      end
      RD_BODY: begin
        mem_read = 1'b1;
        if (accept && idx == last_idx) next_state = is_vec ? PUSH : WAIT_DRAIN;
      end
      PUSH: begin
        if (!sfifo_wrfull && !cfifo_wrfull) begin
          sfifo_wrreq = 1'b1;
          cfifo_wrreq = 1'b1;
          next_state  = RD_META;
        end
      end
      // Hold the mask until every earlier vector has left the pipeline.
      WAIT_DRAIN: if (sc_ready && sfifo_wrempty && !cfifo_wrfull) next_state = SEND_MASK;
      SEND_MASK: begin
        sc_cmd     = SCC_WIDTH'(1);
        next_state = RD_META;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_address <= '0;
      res_addr    <= '0;
      vec_count   <= '0;
      error       <= 1'b0;
      stim_vec    <= '0;
      exp_vec     <= '0;
      idx         <= '0;
      is_vec      <= 1'b0;
    end else begin
      if (start_ok) begin
        mem_address <= cmd_base;
        res_addr    <= res_base;
        vec_count   <= '0;
        error       <= 1'b0;
      end
      if (accept) mem_address <= mem_address + 1'b1;
      if (state == RD_META && accept) begin
        is_vec <= (rec_type == 8'h01);
        idx    <= '0;
        if (rec_type > 8'h02) error <= 1'b1;
      end
      if (state == RD_BODY && accept) begin
        idx <= idx + 1'b1;
        case (idx)
          2'd0:    stim_vec[23:16] <= mem_readdata[7:0];
          2'd1:    stim_vec[15:0]  <= mem_readdata;
          2'd2:    exp_vec[23:16]  <= mem_readdata[7:0];
          default: exp_vec[15:0]   <= mem_readdata;
        endcase
      end
      if (state == PUSH && sfifo_wrreq) begin
        vec_count <= vec_count + 1'b1;
        res_addr  <= res_addr + ADDR_WIDTH'(RESULT_VECTOR_WORDS);
      end
    end
  end

endmodule
